// File: rtl/icache_inv_pkg.sv
// Shared types and width helpers for the I-cache invalidation sequencer.
package icache_inv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    COMPARE = 3'd2,
    WRITE   = 3'd3,
    FLUSH   = 3'd4
  } inv_seq_state_t;

  function automatic int calc_ofs_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int sets, input int words_per_line);
    return 30 - $clog2(sets) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/icache_invalidation_sequencer.sv
// Applies queued I-cache line invalidations (read, compare, invalidate-write, pop)
// and walks every set for a whole-cache flush; fetch owns tag-port priority via tag_gnt.
module icache_invalidation_sequencer
  import icache_inv_pkg::*;
#(
  parameter int SETS           = 512,
  parameter int WAYS           = 2,
  parameter int WORDS_PER_LINE = 4,
  localparam int OFS_W = calc_ofs_w(WORDS_PER_LINE),
  localparam int IDX_W = calc_idx_w(SETS),
  localparam int TAG_W = calc_tag_w(SETS, WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inv_valid,
  input  logic [29:0]           inv_addr,
  output logic                  inv_completed,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  tag_req,
  input  logic                  tag_gnt,
  output logic                  tag_we,
  output logic [IDX_W-1:0]      tag_index,
  output logic [WAYS-1:0]       tag_way_mask,
  input  logic [WAYS*TAG_W-1:0] tag_rd_tag,
  input  logic [WAYS-1:0]       tag_rd_valid,
  input  logic                  fill_we,
  input  logic [IDX_W-1:0]      fill_index,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  inv_seq_state_t   state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic [TAG_W-1:0] tag, tag_nxt;
  logic [WAYS-1:0]  mask, mask_nxt;
  logic [WAYS-1:0]  hit;
  logic             fill_hit;
  logic             unused_ofs;

  // Word offset inside the line does not select anything; the whole line goes.
  assign unused_ofs = ^inv_addr[OFS_W-1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way_cmp
    assign hit[w] = tag_rd_valid[w] & (tag_rd_tag[w*TAG_W +: TAG_W] == tag);
  end

  // A fill into our set invalidates the read data and any pending mask.
  assign fill_hit = fill_we & (fill_index == idx);
  assign busy     = (state != IDLE);

  // Next-state, datapath updates and decoded tag-port / handshake outputs.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    tag_nxt       = tag;
    mask_nxt      = mask;
    cnt_nxt       = cnt;
    inv_completed = 1'b0;
    flush_done    = 1'b0;
    tag_req       = 1'b0;
    tag_we        = 1'b0;
    tag_index     = '0;
    tag_way_mask  = '0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = FLUSH;
        end else if (inv_valid) begin
          state_nxt = READ;
          idx_nxt   = inv_addr[OFS_W+IDX_W-1:OFS_W];
          tag_nxt   = inv_addr[29:OFS_W+IDX_W];
        end else begin
          state_nxt = IDLE;
        end
      end
      READ: begin
        tag_req   = 1'b1;
        tag_index = idx;
        if (tag_gnt) begin
          state_nxt = COMPARE;
        end else begin
          state_nxt = READ;
        end
      end
      COMPARE: begin
        if (fill_hit) begin
          state_nxt = READ;
          mask_nxt  = '0;
        end else if (hit == '0) begin
          inv_completed = 1'b1;
          state_nxt     = IDLE;
        end else begin
          mask_nxt  = hit;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        tag_req      = 1'b1;
        tag_we       = 1'b1;
        tag_index    = idx;
        tag_way_mask = mask;
        if (tag_gnt) begin
          inv_completed = 1'b1;
          mask_nxt      = '0;
          state_nxt     = IDLE;
        end else if (fill_hit) begin
          mask_nxt  = '0;
          state_nxt = READ;
        end else begin
          state_nxt = WRITE;
        end
      end
      FLUSH: begin
        tag_req      = 1'b1;
        tag_we       = 1'b1;
        tag_index    = cnt;
        tag_way_mask = '1;
        if (tag_gnt) begin
          if (cnt == LAST_SET) begin
            flush_done = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = IDLE;
          end else begin
            cnt_nxt = cnt + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and latched invalidation context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      tag   <= '0;
      mask  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      tag   <= tag_nxt;
      mask  <= mask_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_icache_invalidation_sequencer.sv
// Directed self-checking bench for icache_invalidation_sequencer (SETS=8, WAYS=2, 4 words/line).
module tb_icache_invalidation_sequencer;

  logic        clk;
  logic        rst;
  logic        inv_valid;
  logic [29:0] inv_addr;
  logic        inv_completed;
  logic        flush_req;
  logic        flush_done;
  logic        tag_req;
  logic        tag_gnt;
  logic        tag_we;
  logic [2:0]  tag_index;
  logic [1:0]  tag_way_mask;
  logic [49:0] tag_rd_tag;
  logic [1:0]  tag_rd_valid;
  logic        fill_we;
  logic [2:0]  fill_index;
  logic        busy;

  int total;
  int bad;
  int pops;
  int dones;
  int p0;
  int d0;
  logic [9:0] outs;
  logic [9:0] want;

  icache_invalidation_sequencer #(.SETS(8), .WAYS(2), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst(rst),
    .inv_valid(inv_valid), .inv_addr(inv_addr), .inv_completed(inv_completed),
    .flush_req(flush_req), .flush_done(flush_done),
    .tag_req(tag_req), .tag_gnt(tag_gnt), .tag_we(tag_we),
    .tag_index(tag_index), .tag_way_mask(tag_way_mask),
    .tag_rd_tag(tag_rd_tag), .tag_rd_valid(tag_rd_valid),
    .fill_we(fill_we), .fill_index(fill_index), .busy(busy)
  );

  // Observed vector: req, we, mask[1:0], index[2:0], pop, done, busy
  assign outs = {tag_req, tag_we, tag_way_mask, tag_index, inv_completed, flush_done, busy};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (inv_completed) pops <= pops + 1;
    if (flush_done) dones <= dones + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (outs !== 10'b0) begin bad++; $display("FAIL reset_hold: outs=%b want=%b", outs, 10'b0); end
    total++;
    cyc(); rst = 1'b0; #1;
    if (outs !== 10'b0) begin bad++; $display("FAIL reset_release: outs=%b want=%b", outs, 10'b0); end
    total++;
  endtask

  task automatic test_hit();
    logic [24:0] t;
    t = 25'h1ABCDE;
    p0 = pops;
    tag_rd_tag = {t, 25'h0000123}; tag_rd_valid = 2'b11;
    inv_addr = {t, 3'd5, 2'd2}; inv_valid = 1'b1; tag_gnt = 1'b1; #1;
    cyc(); #1;
    want = {1'b1, 1'b0, 2'b00, 3'd5, 1'b0, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL hit_read: outs=%b want=%b", outs, want); end
    total++;
    cyc(); #1;
    want = {1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL hit_compare: outs=%b want=%b", outs, want); end
    total++;
    cyc(); #1;
    want = {1'b1, 1'b1, 2'b10, 3'd5, 1'b1, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL hit_write_pop: outs=%b want=%b", outs, want); end
    total++;
    inv_valid = 1'b0;
    cyc(); #1;
    if (outs !== 10'b0) begin bad++; $display("FAIL hit_idle: outs=%b want=%b", outs, 10'b0); end
    total++;
    if (pops - p0 !== 1) begin bad++; $display("FAIL hit_pop_count: got %0d want 1", pops - p0); end
    total++;
  endtask

  task automatic test_miss();
    logic [24:0] t;
    t = 25'h0F0F0F;
    p0 = pops;
    tag_rd_tag = {25'h0000001, t}; tag_rd_valid = 2'b10;
    inv_addr = {t, 3'd3, 2'd1}; inv_valid = 1'b1; tag_gnt = 1'b1; #1;
    cyc(); #1;
    want = {1'b1, 1'b0, 2'b00, 3'd3, 1'b0, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL miss_read: outs=%b want=%b", outs, want); end
    total++;
    cyc(); #1;
    want = {1'b0, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL miss_pop: outs=%b want=%b", outs, want); end
    total++;
    inv_valid = 1'b0;
    cyc(); #1;
    if (outs !== 10'b0) begin bad++; $display("FAIL miss_idle: outs=%b want=%b", outs, 10'b0); end
    total++;
    if (pops - p0 !== 1) begin bad++; $display("FAIL miss_pop_count: got %0d want 1", pops - p0); end
    total++;
  endtask

  task automatic test_contention();
    logic [24:0] t;
    t = 25'h1555555;
    p0 = pops;
    tag_rd_tag = {25'h0, t}; tag_rd_valid = 2'b01;
    inv_addr = {t, 3'd6, 2'd3}; inv_valid = 1'b1; tag_gnt = 1'b0; #1;
    want = {1'b1, 1'b0, 2'b00, 3'd6, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cyc(); #1;
      if (outs !== want) begin bad++; $display("FAIL contention_wait%0d: outs=%b want=%b", i, outs, want); end
      total++;
    end
    cyc(); tag_gnt = 1'b1; #1;
    if (outs !== want) begin bad++; $display("FAIL contention_gnt: outs=%b want=%b", outs, want); end
    total++;
    if (pops - p0 !== 0) begin bad++; $display("FAIL contention_nopop: got %0d want 0", pops - p0); end
    total++;
    cyc(); #1;
    cyc(); #1;
    want = {1'b1, 1'b1, 2'b01, 3'd6, 1'b1, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL contention_write: outs=%b want=%b", outs, want); end
    total++;
    inv_valid = 1'b0;
    cyc(); #1;
  endtask

  task automatic test_fill_race();
    logic [24:0] t;
    t = 25'h0ABCDEF;
    p0 = pops;
    tag_rd_tag = {t, 25'h0000007}; tag_rd_valid = 2'b11;
    inv_addr = {t, 3'd2, 2'd0}; inv_valid = 1'b1; tag_gnt = 1'b1; #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); tag_gnt = 1'b0; fill_we = 1'b1; fill_index = 3'd3; #1;
    want = {1'b1, 1'b1, 2'b10, 3'd2, 1'b0, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL fill_other_idx: outs=%b want=%b", outs, want); end
    total++;
    cyc(); fill_index = 3'd2; #1;
    if (outs !== want) begin bad++; $display("FAIL fill_still_write: outs=%b want=%b", outs, want); end
    total++;
    cyc(); fill_we = 1'b0; tag_gnt = 1'b1; #1;
    want = {1'b1, 1'b0, 2'b00, 3'd2, 1'b0, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL fill_retry_read: outs=%b want=%b", outs, want); end
    total++;
    cyc(); #1;
    cyc(); #1;
    want = {1'b1, 1'b1, 2'b10, 3'd2, 1'b1, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL fill_final_write: outs=%b want=%b", outs, want); end
    total++;
    inv_valid = 1'b0;
    cyc(); #1;
    if (pops - p0 !== 1) begin bad++; $display("FAIL fill_pop_count: got %0d want 1", pops - p0); end
    total++;
  endtask

  task automatic test_flush();
    logic [24:0] t;
    t = 25'h0123456;
    p0 = pops; d0 = dones;
    tag_rd_tag = {25'h0, t}; tag_rd_valid = 2'b01;
    inv_addr = {t, 3'd4, 2'd0}; inv_valid = 1'b1; flush_req = 1'b1; tag_gnt = 1'b1; #1;
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      want = {1'b1, 1'b1, 2'b11, 3'(k), 1'b0, (k == 7), 1'b1};
      if (outs !== want) begin bad++; $display("FAIL flush_set%0d: outs=%b want=%b", k, outs, want); end
      total++;
    end
    flush_req = 1'b0; tag_rd_valid = 2'b00;
    cyc(); #1;
    if (outs !== 10'b0) begin bad++; $display("FAIL flush_idle: outs=%b want=%b", outs, 10'b0); end
    total++;
    cyc(); #1;
    want = {1'b1, 1'b0, 2'b00, 3'd4, 1'b0, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL flush_then_read: outs=%b want=%b", outs, want); end
    total++;
    cyc(); #1;
    want = {1'b0, 1'b0, 2'b00, 3'd0, 1'b1, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL flush_then_miss: outs=%b want=%b", outs, want); end
    total++;
    inv_valid = 1'b0;
    cyc(); #1;
    if (dones - d0 !== 1) begin bad++; $display("FAIL flush_done_count: got %0d want 1", dones - d0); end
    total++;
    if (pops - p0 !== 1) begin bad++; $display("FAIL flush_pop_count: got %0d want 1", pops - p0); end
    total++;
  endtask

  task automatic test_reset_in_write();
    logic [24:0] t;
    t = 25'h0000ABC;
    p0 = pops;
    tag_rd_tag = {25'h0, t}; tag_rd_valid = 2'b01;
    inv_addr = {t, 3'd1, 2'd2}; inv_valid = 1'b1; tag_gnt = 1'b1; #1;
    cyc(); #1;
    cyc(); #1;
    cyc(); tag_gnt = 1'b0; #1;
    want = {1'b1, 1'b1, 2'b01, 3'd1, 1'b0, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL rstw_write: outs=%b want=%b", outs, want); end
    total++;
    rst = 1'b1; #1;
    if (outs !== 10'b0) begin bad++; $display("FAIL rstw_async: outs=%b want=%b", outs, 10'b0); end
    total++;
    cyc(); rst = 1'b0; tag_gnt = 1'b1; #1;
    if (outs !== 10'b0) begin bad++; $display("FAIL rstw_idle: outs=%b want=%b", outs, 10'b0); end
    total++;
    if (pops - p0 !== 0) begin bad++; $display("FAIL rstw_nopop: got %0d want 0", pops - p0); end
    total++;
    cyc(); #1;
    want = {1'b1, 1'b0, 2'b00, 3'd1, 1'b0, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL rstw_reread: outs=%b want=%b", outs, want); end
    total++;
    cyc(); #1;
    cyc(); #1;
    want = {1'b1, 1'b1, 2'b01, 3'd1, 1'b1, 1'b0, 1'b1};
    if (outs !== want) begin bad++; $display("FAIL rstw_rewrite: outs=%b want=%b", outs, want); end
    total++;
    inv_valid = 1'b0;
    cyc(); #1;
    if (pops - p0 !== 1) begin bad++; $display("FAIL rstw_pop_count: got %0d want 1", pops - p0); end
    total++;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    inv_valid = 1'b0; inv_addr = 30'd0; flush_req = 1'b0; tag_gnt = 1'b0;
    tag_rd_tag = 50'd0; tag_rd_valid = 2'b00; fill_we = 1'b0; fill_index = 3'd0;
    total = 0; bad = 0; pops = 0; dones = 0;
    test_reset();
    test_hit();
    test_miss();
    test_contention();
    test_fill_race();
    test_flush();
    test_reset_in_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
